// File: rtl/fpu_mul_arbiter.sv
// Round-robin arbiter that time-shares one fpuMul16 multiplier between NREQ requesters.
// Each operation resets the unit, starts it, waits for done (or times out) and returns the result.
module fpu_mul_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned FLAGW   = 5
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [16*NREQ-1:0]   req_op1,
  input  logic [16*NREQ-1:0]   req_op2,
  output logic [NREQ-1:0]      resp_valid,
  input  logic [NREQ-1:0]      resp_ready,
  output logic [15:0]          resp_result,
  output logic [3:0]           resp_cond,
  output logic [FLAGW-1:0]     resp_flags,
  output logic                 resp_timeout,
  output logic [15:0]          mul_in1,
  output logic [15:0]          mul_in2,
  output logic                 mul_start,
  output logic                 mul_reset,
  input  logic [15:0]          mul_out,
  input  logic                 mul_done,
  input  logic [3:0]           mul_cond,
  input  logic [FLAGW-1:0]     mul_flags,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [15:0] QNaN = 16'h7E00;

  typedef enum logic [2:0] {StIdle, StClear, StStart, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [15:0]       in1_q, in1_d, in2_q, in2_d;
  logic [15:0]       res_q, res_d;
  logic [3:0]        cond_q, cond_d;
  logic [FLAGW-1:0]  flags_q, flags_d;
  logic              tmo_q, tmo_d;
  logic              err_q, err_d;

  logic [IdxW-1:0]   grant;
  logic              grant_vld;
  logic [IdxW-1:0]   idx;
  logic [15:0]       sel_op1, sel_op2;

  // Scan from the highest offset down so the last hit is the first one after ptr.
  always_comb begin
    grant     = ptr_q;
    grant_vld = 1'b0;
    idx       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IdxW'((int'(ptr_q) + k) % int'(NREQ));
      if (req_valid[idx]) begin
        grant     = idx;
        grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    sel_op1 = '0;
    sel_op2 = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (IdxW'(i) == grant) begin
        sel_op1 = req_op1[16*i +: 16];
        sel_op2 = req_op2[16*i +: 16];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    in1_d     = in1_q;
    in2_d     = in2_q;
    res_d     = res_q;
    cond_d    = cond_q;
    flags_d   = flags_q;
    tmo_d     = tmo_q;
    err_d     = err_q;
    req_ready = '0;
    resp_valid = '0;

    unique case (state_q)
      StIdle: begin
        if (grant_vld && reset_n) begin
          req_ready[grant] = 1'b1;
        end
        if (grant_vld) begin
          in1_d   = sel_op1;
          in2_d   = sel_op2;
          owner_d = grant;
          ptr_d   = (grant == IdxW'(NREQ - 1)) ? '0 : grant + 1'b1;
          state_d = StClear;
        end
      end
      StClear: state_d = StStart;
      StStart: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (mul_done) begin
          res_d   = mul_out;
          cond_d  = mul_cond;
          flags_d = mul_flags;
          tmo_d   = 1'b0;
          state_d = StResp;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          res_d   = QNaN;
          cond_d  = '0;
          flags_d = '0;
          tmo_d   = 1'b1;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        resp_valid[owner_q] = 1'b1;
        if (resp_ready[owner_q]) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      in1_q   <= '0;
      in2_q   <= '0;
      res_q   <= '0;
      cond_q  <= '0;
      flags_q <= '0;
      tmo_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      res_q   <= res_d;
      cond_q  <= cond_d;
      flags_q <= flags_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  // The unit is also held in reset while this block is.
  assign mul_reset    = !reset_n || (state_q == StClear);
  assign mul_start    = (state_q == StStart);
  assign mul_in1      = in1_q;
  assign mul_in2      = in2_q;
  assign resp_result  = res_q;
  assign resp_cond    = cond_q;
  assign resp_flags   = flags_q;
  assign resp_timeout = tmo_q;
  assign busy         = (state_q != StIdle);
  assign timeout_err  = err_q;

endmodule

// File: doc/fpu_mul_arbiter.md
Name: fpu_mul_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one fpuMul16 multiplication coprocessor between NREQ requesters.
- fpuMul16's done is sticky and clears only on its reset, so this block does the following for every operation:
  - drives the unit's active-high reset for one cycle;
  - holds the operands stable in registers;
  - pulses start;
  - waits for done;
  - returns result, condition codes and status flags to the owning requester over a valid/ready handshake.
- Sits between the instruction-issue logic and the FPU multiply datapath.

Parameters:
NREQ, 4, number of requesters (2..8)
TIMEOUT, 64, WAIT-state cycles without mul_done before an operation is aborted
FLAGW, 5, width of opStatusFlag_t

Ports:
clock  input  1  system clock
reset_n  input  1  reset, asynchronous, active-low
req_valid  input  NREQ  per-requester operation request
req_ready  output  NREQ  one-hot accept; asserted only in IDLE, to the granted requester
req_op1  input  16*NREQ  fp16 operand 1, requester i at bits [16i+15:16i]
req_op2  input  16*NREQ  fp16 operand 2, same packing
resp_valid  output  NREQ  one-hot response valid to the owning requester
resp_ready  input  NREQ  per-requester response accept
resp_result  output  16  fp16 product
resp_cond  output  4  {Z,C,N,V} from the unit
resp_flags  output  FLAGW  status flags from the unit
resp_timeout  output  1  qualifies resp_valid: the operation was aborted
mul_in1  output  16  operand-1 register to fpuMul16.fpuIn1
mul_in2  output  16  operand-2 register to fpuMul16.fpuIn2
mul_start  output  1  one-cycle start pulse to the unit
mul_reset  output  1  active-high reset to the unit
mul_out  input  16  fpuMul16.fpuOut
mul_done  input  1  fpuMul16.done
mul_cond  input  4  fpuMul16.condCodes
mul_flags  input  FLAGW  fpuMul16.opStatusFlags
busy  output  1  state != IDLE
timeout_err  output  1  sticky; set on any timeout, cleared only by reset

Behaviour:
- States: IDLE, CLEAR, START, WAIT, RESP.
- Reset (reset_n low, asynchronous):
  - state = IDLE; rr pointer = 0; timeout counter = 0; timeout_err = 0.
  - Operand and result registers = 0.
  - req_ready = 0, resp_valid = 0, mul_start = 0, resp_timeout = 0.
  - mul_reset = 1 combinationally while reset_n is low.
- Arbitration (IDLE):
  - grant g = first index with req_valid set, scanning ptr, ptr+1, ... mod NREQ.
  - req_ready[g] = 1 combinationally in IDLE; all other req_ready bits 0; none if no req_valid.
  - On the handshake edge: latch op1/op2 of g into mul_in1/mul_in2, latch owner = g, set ptr = (g+1) mod NREQ, go to CLEAR.
- CLEAR: mul_reset = 1 for exactly one cycle → START.
- START: mul_start = 1 for exactly one cycle; counter = 0 → WAIT.
- WAIT:
  - mul_done = 1: latch mul_out, mul_cond and mul_flags into the result registers; resp_timeout = 0 → RESP.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 with mul_done still low:
    - result = 16'h7E00 (qNaN), cond = 0, flags = 0;
    - resp_timeout = 1; timeout_err = 1;
    - go to RESP.
  - mul_done takes priority over timeout in the same cycle.
- RESP:
  - resp_valid[owner] = 1 and all result outputs are held stable until resp_ready[owner] = 1.
  - Handshake edge → IDLE.
  - resp_ready of non-owners is ignored.
  - No new grant is made during RESP.
  - The earliest next req_ready is the cycle after the RESP handshake.
- Handshake timing:
  - Handshake at edge T → CLEAR at T+1, START at T+2, WAIT from T+3.
  - resp_valid rises the cycle after mul_done is sampled.
- Operand stability: mul_in1 and mul_in2 are unchanged from CLEAR through RESP, because the unit's normalizer reads its operands combinationally.
- mul_reset = 1 only in CLEAR or during reset. mul_start is never asserted in the same cycle as mul_reset.
- req_valid is allowed to drop without a handshake; a request is not sticky inside the arbiter.
- Asynchronous reset in the middle of an operation: the result is discarded, no response is issued, and the unit is reset.

Test Plan:
- Single requester 0: op1 = 3E00 (1.5), op2 = 4000 (2.0) → req_ready[0] in the same cycle; mul_reset at T+1 and mul_start at T+2, each 1 cycle; resp_valid[0] with resp_result = 4200 (3.0), resp_timeout = 0.
- Fairness: all four requesters valid continuously with ptr = 0 → grants in order 0,1,2,3,0; requester 2 dropping req_valid → sequence 0,1,3,0.
- Back-pressure: resp_ready[1] held low for 10 cycles after resp_valid[1] → resp_result stable, no req_ready to anyone, IDLE the cycle after the handshake.
- Back-to-back operations 3C00×3C00 then 4000×4000 from the same requester → second product 4400; mul_reset pulses before each start (the unit's sticky done must not leak into the second operation).
- Timeout: stub that never asserts mul_done, TIMEOUT = 8 → response at WAIT+8 with result 7E00, resp_timeout = 1, timeout_err = 1 and held until reset.
- Reset mid-WAIT: reset_n low for 1 cycle → all outputs at their reset values, mul_reset high while reset_n is low, no resp_valid, ptr = 0.
